// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified memory.
interface mem_access_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_cs;
  logic          mem_r;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_cs, mem_r, mem_w, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_cs, mem_r, mem_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Arbitrates CPU fetch and data ports onto one fixed-latency single-port memory.
// Optional macro MEM_ARB_RR_EN: round-robin between simultaneous requests.
module mem_access_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input logic                  clk,
  input logic                  rst,
  mem_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_t        state, state_n;
  gnt_t          gnt, gnt_n;
  logic [3:0]    cnt, cnt_n;
  logic          i_ack, i_ack_n, d_ack, d_ack_n;
  logic          mem_cs, mem_cs_n, mem_r, mem_r_n, mem_w, mem_w_n;
  logic [AW-1:0] mem_addr, mem_addr_n;
  logic [DW-1:0] mem_wdata, mem_wdata_n;
  logic [DW-1:0] i_rdata, i_rdata_n, d_rdata, d_rdata_n;
  logic          pick_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= GNT_I;
      cnt       <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_cs    <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      cnt       <= cnt_n;
      i_ack     <= i_ack_n;
      d_ack     <= d_ack_n;
      mem_cs    <= mem_cs_n;
      mem_r     <= mem_r_n;
      mem_w     <= mem_w_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

  // gnt keeps the most recent grant while idle, so it doubles as last-grant.
`ifdef MEM_ARB_RR_EN
  assign pick_d = bus.d_req && (!bus.i_req || gnt == GNT_I);
`else
  assign pick_d = bus.d_req;
`endif

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    cnt_n       = cnt;
    i_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    mem_cs_n    = mem_cs;
    mem_r_n     = mem_r;
    mem_w_n     = mem_w;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    case (state)
      IDLE: begin
        if (pick_d) begin
          gnt_n       = GNT_D;
          mem_addr_n  = bus.d_addr;
          mem_wdata_n = bus.d_wdata;
          mem_cs_n    = 1'b1;
          mem_r_n     = !bus.d_we;
          mem_w_n     = bus.d_we;
          cnt_n       = '0;
          state_n     = ACCESS;
        end else if (bus.i_req) begin
          gnt_n       = GNT_I;
          mem_addr_n  = bus.i_addr;
          mem_cs_n    = 1'b1;
          mem_r_n     = 1'b1;
          mem_w_n     = 1'b0;
          cnt_n       = '0;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) begin
          if (gnt == GNT_I) begin
            i_rdata_n = bus.mem_rdata;
            i_ack_n   = 1'b1;
          end else begin
            if (mem_r) d_rdata_n = bus.mem_rdata;
            d_ack_n = 1'b1;
          end
          mem_cs_n = 1'b0;
          mem_r_n  = 1'b0;
          mem_w_n  = 1'b0;
          state_n  = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.i_ack     = i_ack;
  assign bus.d_ack     = d_ack;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_cs    = mem_cs;
  assign bus.mem_r     = mem_r;
  assign bus.mem_w     = mem_w;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed table, random pairs vs. a timing model, corner sequences.
module tb_mem_access_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.AW(AW), .DW(DW)) ifc2 ();
  mem_access_arbiter_if #(.AW(AW), .DW(DW)) ifc1 ();

  mem_access_arbiter #(.MEM_LAT(L), .AW(AW), .DW(DW)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));
  mem_access_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  int checks = 0;
  int errors = 0;
  string cur_tag = "";

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0004: memf = 32'h8C01_0000;
      32'h0000_0020: memf = 32'h1234_5678;
      default:       memf = {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Memory model: data is only valid in the last cycle of each access.
  int cs_cnt2 = 0;
  int cs_cnt1 = 0;
  always @(posedge clk) begin
    cs_cnt2 <= ifc2.mem_cs ? cs_cnt2 + 1 : 0;
    cs_cnt1 <= ifc1.mem_cs ? cs_cnt1 + 1 : 0;
  end
  always_comb ifc2.mem_rdata = (ifc2.mem_cs && cs_cnt2 == L - 1) ? memf(ifc2.mem_addr)
                                                                   : 32'hBAD0_0000 + 32'(cs_cnt2);
  always_comb ifc1.mem_rdata = (ifc1.mem_cs && cs_cnt1 == 0) ? memf(ifc1.mem_addr)
                                                              : 32'hBAD1_0000 + 32'(cs_cnt1);

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %b expected %b at %0t", cur_tag, name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h at %0t", cur_tag, name, act, exp, $time);
    end
  endtask

  // Reference state: last captured read data and who was granted last.
  logic [31:0] m_irdata, m_drdata;
  bit          m_last_d;

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dwe; logic [31:0] da; logic [31:0] dd;
    int ei; int ed; logic [31:0] eir; logic [31:0] edr;
  } vec_t;

  // Runs one request set starting in IDLE at cycle 0. ei/ed: expected ack cycle (0 = none).
  task automatic run_pair(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                          input logic [31:0] da, input logic [31:0] dd, input int ei, input int ed,
                          input logic [31:0] eir, input logic [31:0] edr, input bit scr);
    logic [31:0] old_i = m_irdata;
    logic [31:0] old_d = m_drdata;
    int last = (ei > ed) ? ei : ed;
    bit first_i = (ei != 0) && (ed == 0 || ei < ed);
    logic drop_i, drop_d, in_i, in_d;
    ifc2.i_req = ir; ifc2.i_addr = ia;
    ifc2.d_req = dr; ifc2.d_we = dwe; ifc2.d_addr = da; ifc2.d_wdata = dd;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      in_i = (ei != 0) && c >= ei - L && c <= ei - 1;
      in_d = (ed != 0) && c >= ed - L && c <= ed - 1;
      chk1("mem_cs", ifc2.mem_cs, in_i || in_d);
      chk1("mem_r", ifc2.mem_r, in_i || (in_d && !dwe));
      chk1("mem_w", ifc2.mem_w, in_d && dwe);
      if (in_i) chk32("mem_addr_i", ifc2.mem_addr, ia);
      if (in_d) chk32("mem_addr_d", ifc2.mem_addr, da);
      if (in_d && dwe) chk32("mem_wdata", ifc2.mem_wdata, dd);
      chk1("i_ack", ifc2.i_ack, ei != 0 && c == ei);
      chk1("d_ack", ifc2.d_ack, ed != 0 && c == ed);
      chk32("i_rdata", ifc2.i_rdata, (ei != 0 && c >= ei) ? eir : old_i);
      chk32("d_rdata", ifc2.d_rdata, (ed != 0 && c >= ed) ? edr : old_d);
      drop_i = ifc2.i_ack;
      drop_d = ifc2.d_ack;
      @(posedge clk); #1;
      if (drop_i) ifc2.i_req = 1'b0;
      if (drop_d) ifc2.d_req = 1'b0;
      if (scr && c + 1 <= L) begin
        if (first_i) ifc2.i_addr = $urandom;
        else begin ifc2.d_addr = $urandom; ifc2.d_wdata = $urandom; end
      end
    end
    ifc2.i_req = 1'b0;
    ifc2.d_req = 1'b0;
    repeat (L + 2) @(posedge clk);
    #1;
    m_irdata = eir;
    m_drdata = edr;
    if (ir && dr) m_last_d = (ed > ei);
    else m_last_d = dr;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ifc2.i_req = 0; ifc2.i_addr = '0; ifc2.d_req = 0; ifc2.d_we = 0; ifc2.d_addr = '0; ifc2.d_wdata = '0;
    ifc1.i_req = 0; ifc1.i_addr = '0; ifc1.d_req = 0; ifc1.d_we = 0; ifc1.d_addr = '0; ifc1.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cur_tag = "reset";
    chk1("i_ack", ifc2.i_ack, 1'b0);
    chk1("d_ack", ifc2.d_ack, 1'b0);
    chk1("mem_cs", ifc2.mem_cs, 1'b0);
    chk1("mem_r", ifc2.mem_r, 1'b0);
    chk1("mem_w", ifc2.mem_w, 1'b0);
    chk32("mem_addr", ifc2.mem_addr, 32'h0);
    chk32("mem_wdata", ifc2.mem_wdata, 32'h0);
    chk32("i_rdata", ifc2.i_rdata, 32'h0);
    chk32("d_rdata", ifc2.d_rdata, 32'h0);
    chk1("lat1_cs", ifc1.mem_cs, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_irdata = '0; m_drdata = '0; m_last_d = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  vec_t tbl[5];

  initial begin
    logic ir, dr, dwe, d_first;
    logic [31:0] ia, da, dd;
    int ei, ed, k, cs_total;
    logic ack_seen;

    tbl[0] = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 3, 0, 32'h8C01_0000, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 3, 32'h8C01_0000, 32'h0};
`ifdef MEM_ARB_RR_EN
    tbl[2] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h20, 32'h0, 3, 7, memf(32'h100), 32'h1234_5678};
`else
    tbl[2] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h20, 32'h0, 7, 3, memf(32'h100), 32'h1234_5678};
`endif
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 0, 3, memf(32'h100), memf(32'h24)};
`ifdef MEM_ARB_RR_EN
    tbl[4] = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 3, 7, memf(32'h8), memf(32'h24)};
`else
    tbl[4] = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 7, 3, memf(32'h8), memf(32'h24)};
`endif

    do_reset();

    for (int t = 0; t < 5; t++) begin
      cur_tag = $sformatf("vec%0d", t);
      run_pair(tbl[t].ir, tbl[t].ia, tbl[t].dr, tbl[t].dwe, tbl[t].da, tbl[t].dd,
               tbl[t].ei, tbl[t].ed, tbl[t].eir, tbl[t].edr, 1'b1);
    end

    for (int n = 0; n < 24; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      dwe = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; dd = $urandom;
`ifdef MEM_ARB_RR_EN
      d_first = dr && !(ir && m_last_d);
`else
      d_first = dr;
`endif
      ei = ir ? ((dr && d_first) ? 2 * L + 3 : L + 1) : 0;
      ed = dr ? ((ir && !d_first) ? 2 * L + 3 : L + 1) : 0;
      cur_tag = $sformatf("rand%0d", n);
      run_pair(ir, ia, dr, dwe, da, dd, ei, ed,
               ir ? memf(ia) : m_irdata, (dr && !dwe) ? memf(da) : m_drdata,
               1'($urandom_range(0, 1)));
    end

    // Request withdrawn and address changed right after the grant: access still completes.
    cur_tag = "drop_mid";
    ifc2.i_req = 1'b1; ifc2.i_addr = 32'h44;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk1("i_ack", ifc2.i_ack, c == 3);
      chk1("mem_cs", ifc2.mem_cs, c == 1 || c == 2);
      if (c == 1 || c == 2) chk32("mem_addr", ifc2.mem_addr, 32'h44);
      @(posedge clk); #1;
      if (c == 0) begin ifc2.i_req = 1'b0; ifc2.i_addr = 32'h99; end
    end
    chk32("i_rdata", ifc2.i_rdata, memf(32'h44));

    // Reset in cycle 2 of a fetch aborts it; the held request restarts from IDLE.
    cur_tag = "rst_mid";
    ifc2.i_req = 1'b1; ifc2.i_addr = 32'h40;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk1("mem_r", ifc2.mem_r, 1'b0);
        chk32("mem_addr", ifc2.mem_addr, 32'h0);
        chk32("i_rdata", ifc2.i_rdata, 32'h0);
        chk32("d_rdata", ifc2.d_rdata, 32'h0);
      end
      chk1("mem_cs", ifc2.mem_cs, c == 1 || c == 2 || c == 4 || c == 5);
      chk1("i_ack", ifc2.i_ack, c == 6);
      ack_seen = ifc2.i_ack;
      @(posedge clk); #1;
      if (c == 1) rst = 1'b0;
      if (c == 2) rst = 1'b1;
      if (ack_seen) ifc2.i_req = 1'b0;
    end
    chk32("i_rdata_after", ifc2.i_rdata, memf(32'h40));
    ifc2.i_req = 1'b0;

    // MEM_LAT=1: fetches at 0x0, 0x4, 0x8 held back to back.
    cur_tag = "lat1";
    k = 0; cs_total = 0;
    ifc1.i_req = 1'b1; ifc1.i_addr = 32'h0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk1("i_ack", ifc1.i_ack, c == 2 || c == 5 || c == 8);
      chk1("mem_cs", ifc1.mem_cs, c == 1 || c == 4 || c == 7);
      if (ifc1.mem_cs) begin
        cs_total++;
        chk32("mem_addr", ifc1.mem_addr, 32'(4 * ((c - 1) / 3)));
      end
      if (ifc1.i_ack) chk32("i_rdata", ifc1.i_rdata, memf(32'(4 * k)));
      ack_seen = ifc1.i_ack;
      @(posedge clk); #1;
      if (ack_seen) begin
        k++;
        if (k >= 3) ifc1.i_req = 1'b0;
        else ifc1.i_addr = 32'(4 * k);
      end
    end
    chk32("cs_cycles", 32'(cs_total), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
